// File: rtl/decryption_block.sv
// decryption_block: iterative AES-128 inverse cipher, one inverse round per enabled clock.
// Build option AES_DEC_KEY_LATCH_EN: capture the full key schedule at the accepting edge.
module decryption_block (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          start,
    input  logic [127:0]  data,
    input  logic [1407:0] allKeys,
    output logic [127:0]  out,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [127:0]       state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [127:0]       out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [127:0]       inv_core;
    logic [0:10][127:0] rk_use;
    logic               accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x240 = x15;
        for (int unsigned i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Byte k sits at bits [127-8k -: 8]; row r of column c is byte 4c+r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign accept = enable && (fsm_q == IDLE) && start;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [1407:0] keys_q, keys_d;

    always_comb begin
        keys_d = keys_q;
        if (accept) keys_d = allKeys;
    end

    always_ff @(posedge clk) begin
        if (reset) keys_q <= '0;
        else       keys_q <= keys_d;
    end

    assign rk_use = keys_q;
`else
    assign rk_use = allKeys;
`endif

    // The counter reaches 0 on entry to FINAL, so rk_use[cnt_q] also selects rk0 there.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        inv_core = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_use[cnt_q];
        if (enable) begin
            unique case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_d = data ^ allKeys[127:0];
                        cnt_d   = 4'd9;
                        busy_d  = 1'b1;
                        fsm_d   = ROUND;
                    end
                end
                ROUND: begin
                    state_d = inv_mix_columns(inv_core);
                    cnt_d   = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) fsm_d = FINAL;
                end
                FINAL: begin
                    out_d  = inv_core;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = IDLE;
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_decryption_block.sv
// Self-checking bench for decryption_block: FIPS-197 vectors plus random vectors from a forward AES model.
module tb_decryption_block;
    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          start;
    logic [127:0]  data;
    logic [1407:0] allKeys;
    logic [127:0]  out;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    decryption_block dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (start),
        .data    (data),
        .allKeys (allKeys),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        logic [127:0] pt;
        int unsigned  exp_cyc;
        int unsigned  lat;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned busy_cnt = 0;
    logic [7:0]  sbox_tab [0:255];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = tb_xt(p);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        if (x != 8'h00) begin
            b = 8'h01;
            for (int i = 0; i < 254; i++) b = tb_mul(b, x);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] ks;
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rc, 24'h0};
                rc = tb_xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ks);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ ks[1407 -: 128];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) t[127-8*k -: 8] = sbox_tab[s[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[127-8*(4*c+r) -: 8] = t[127-8*(4*((c+r)%4)+r) -: 8];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    s[127-32*c -: 8] = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
                    s[119-32*c -: 8] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
                    s[111-32*c -: 8] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
                    s[103-32*c -: 8] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
                end
            end
            s = s ^ ks[1407-128*rnd -: 128];
        end
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        else if (!done) busy_cnt = 0;
        if (done) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 128'd1, 128'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("out", out, e.pt);
                check_eq("done_cycle", 128'(cyc), 128'(e.exp_cyc));
                check_eq("busy_cycles", 128'(busy_cnt), 128'(e.lat));
            end
            busy_cnt = 0;
        end
    end

    // Called at a falling edge; the next rising edge is the accepting edge.
    task automatic send(input logic [127:0] ct, input logic [127:0] pt,
                        input int unsigned lat, input bit expect_it);
        exp_t e;
        data  = ct;
        start = 1'b1;
        if (expect_it) begin
            e.pt      = pt;
            e.exp_cyc = cyc + 1 + lat;
            e.lat     = lat;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) check_eq("done_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1407:0] ks_c1, ks_b, ks_r;
        logic [127:0]  key_r, pt_r;

        reset   = 1'b1;
        enable  = 1'b1;
        start   = 1'b0;
        data    = '0;
        allKeys = '0;
        for (int i = 0; i < 256; i++) sbox_tab[i] = fwd_sbox(8'(i));
        ks_c1 = key_expand(C1_KEY);
        ks_b  = key_expand(B_KEY);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_out", out, '0);
        check_eq("rst_busy", 128'(busy), '0);
        check_eq("rst_done", 128'(done), '0);

        // C.1 followed back-to-back by B
        allKeys = ks_c1;
        send(C1_CT, C1_PT, 10, 1'b1);
        wait_done(40);
        allKeys = ks_b;
        send(B_CT, B_PT, 10, 1'b1);
        wait_done(40);

        // done drops on the next edge even while stalled; out holds
        enable = 1'b0;
        @(negedge clk);
        check_eq("done_clear_stalled", 128'(done), '0);
        check_eq("out_hold", out, B_PT);
        enable = 1'b1;

        // Three stalled edges after E4
        allKeys = ks_c1;
        send(C1_CT, C1_PT, 13, 1'b1);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_done(40);
        @(negedge clk);

        // start during round 5 is dropped
        send(C1_CT, C1_PT, 10, 1'b1);
        repeat (4) @(negedge clk);
        data  = 128'hdeadbeef_01234567_89abcdef_f00dcafe;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40);
        repeat (15) @(negedge clk);

        // start with enable low is dropped
        enable = 1'b0;
        data   = C1_CT;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        enable = 1'b1;
        check_eq("dis_start_busy", 128'(busy), '0);
        repeat (14) @(negedge clk);

        // Reset at E6 together with a start: both the operation and the start are dropped
        send(C1_CT, C1_PT, 0, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("abort_out", out, '0);
        check_eq("abort_busy", 128'(busy), '0);
        check_eq("abort_done", 128'(done), '0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_idle_busy", 128'(busy), '0);
        send(C1_CT, C1_PT, 10, 1'b1);
        wait_done(40);

        // Random keys and plaintexts through the forward model, chained back-to-back
        for (int n = 0; n < 4; n++) begin
            key_r   = {$urandom, $urandom, $urandom, $urandom};
            pt_r    = {$urandom, $urandom, $urandom, $urandom};
            ks_r    = key_expand(key_r);
            allKeys = ks_r;
            send(encrypt(pt_r, ks_r), pt_r, 10, 1'b1);
            wait_done(40);
        end

`ifdef AES_DEC_KEY_LATCH_EN
        allKeys = ks_c1;
        send(C1_CT, C1_PT, 10, 1'b1);
        allKeys = '0;
        wait_done(40);
`endif

        repeat (3) @(negedge clk);
        check_eq("pending", 128'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
